// File: rtl/rom_arb_pkg.sv
// Shared FSM encoding and default geometry for the ROM arbiter slice.
package rom_arb_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int NREQ_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Client-side request/response bus plus ROM address/data pair of the ROM arbiter.
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NREQ  = NREQ_DEF
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*DEPTH-1:0] addr;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [WIDTH-1:0]      rdata;
  logic [DEPTH-1:0]      rom_a;
  logic [WIDTH-1:0]      rom_q;

  // master: the requesters together with the external ROM
  modport master (
    output req, addr, rom_q,
    input  gnt, rvalid, rdata, rom_a
  );

  modport slave (
    input  req, addr, rom_q,
    output gnt, rvalid, rdata, rom_a
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner select: round-robin from last+1 by default, or fixed
// lowest-index priority (no last input) when ROM_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifndef ROM_ARB_FIXED_PRIO_EN
  input  logic [LW-1:0]   last,
`endif
  output logic [NREQ-1:0] onehot,
  output logic [LW-1:0]   idx,
  output logic            any
);

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Downward scan: the lowest requesting index is the last one kept.
  always_comb begin
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = req[i] ? LW'(i) : idx;
    end
  end
`else
  logic [LW-1:0] cand;
  logic          found;

  // First requester found searching upward from last+1, wrapping modulo NREQ.
  always_comb begin
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand  = LW'((int'(last) + i) % NREQ);
      idx   = (req[cand] && !found) ? cand : idx;
      found = found | req[cand];
    end
  end
`endif

  assign any = |req;

  // One-hot decode of the winner index, empty when nobody requests.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      onehot[i] = any && (idx == LW'(i));
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one combinational lookup ROM among NREQ requesters, one read per 3 cycles.
// Define ROM_ARB_FIXED_PRIO_EN for fixed lowest-index priority without last-winner state.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input logic          clk,
  input logic          rst,
  rom_arbiter_if.slave bus
);

  localparam int LW = $clog2(NREQ);

  state_t           state;
  state_t           state_nxt;
  logic [NREQ-1:0]  gnt_reg;
  logic [NREQ-1:0]  gnt_nxt;
  logic [NREQ-1:0]  rvalid_reg;
  logic [NREQ-1:0]  rvalid_nxt;
  logic [WIDTH-1:0] rdata_reg;
  logic [WIDTH-1:0] rdata_nxt;
  logic [DEPTH-1:0] rom_a_reg;
  logic [DEPTH-1:0] rom_a_nxt;
  logic [DEPTH-1:0] sel_addr;
  logic [NREQ-1:0]  pick_onehot;
  logic [LW-1:0]    pick_idx;
  logic             pick_any;
`ifndef ROM_ARB_FIXED_PRIO_EN
  logic [LW-1:0]    last_reg;
  logic [LW-1:0]    last_nxt;
  logic [LW-1:0]    win_reg;
  logic [LW-1:0]    win_nxt;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .req    (bus.req),
`ifndef ROM_ARB_FIXED_PRIO_EN
    .last   (last_reg),
`endif
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Winner's address slice, AND-OR muxed by the one-hot pick.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | ({DEPTH{pick_onehot[i]}} & bus.addr[i*DEPTH +: DEPTH]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = pick_any ? READ : IDLE;
      READ:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration state.
  always_comb begin
    gnt_nxt    = '0;
    rvalid_nxt = '0;
    rdata_nxt  = rdata_reg;
    rom_a_nxt  = rom_a_reg;
`ifndef ROM_ARB_FIXED_PRIO_EN
    last_nxt   = last_reg;
    win_nxt    = win_reg;
`endif
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_nxt   = pick_onehot;
          rom_a_nxt = sel_addr;
`ifndef ROM_ARB_FIXED_PRIO_EN
          win_nxt   = pick_idx;
`endif
        end else begin
          gnt_nxt   = '0;
        end
      end
      READ: begin
        rdata_nxt  = bus.rom_q;
        rvalid_nxt = gnt_reg;
      end
      RESP: begin
`ifndef ROM_ARB_FIXED_PRIO_EN
        last_nxt   = win_reg;
`endif
        rvalid_nxt = '0;
      end
      default: begin
        gnt_nxt    = '0;
        rvalid_nxt = '0;
      end
    endcase
  end

  // Output and arbitration registers; last starts at NREQ-1 so requester 0 leads.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg    <= '0;
      rvalid_reg <= '0;
      rdata_reg  <= '0;
      rom_a_reg  <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_reg   <= LW'(NREQ - 1);
      win_reg    <= '0;
`endif
    end else begin
      gnt_reg    <= gnt_nxt;
      rvalid_reg <= rvalid_nxt;
      rdata_reg  <= rdata_nxt;
      rom_a_reg  <= rom_a_nxt;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_reg   <= last_nxt;
      win_reg    <= win_nxt;
`endif
    end
  end

  assign bus.gnt    = gnt_reg;
  assign bus.rvalid = rvalid_reg;
  assign bus.rdata  = rdata_reg;
  assign bus.rom_a  = rom_a_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: a transaction-level model queues expected
// grants/responses, and a negedge monitor compares every cycle.
module tb_rom_arbiter;

  localparam int WIDTH = rom_arb_pkg::WIDTH_DEF;
  localparam int DEPTH = rom_arb_pkg::DEPTH_DEF;
  localparam int NREQ  = rom_arb_pkg::NREQ_DEF;
  localparam int ROMN  = 1 << DEPTH;

  typedef struct {
    int               cyc;
    logic [NREQ-1:0]  oh;
    logic [DEPTH-1:0] a;
    logic [WIDTH-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) bus ();

  rom_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [WIDTH-1:0] rom_mem [ROMN];
  assign bus.rom_q = rom_mem[bus.rom_a];

  exp_t             gq[$];
  exp_t             rq[$];
  int               cyc      = 0;
  int               checks   = 0;
  int               errors   = 0;
  bit               mon_en   = 1'b0;
  int               m_phase  = 0;
  int               m_last   = NREQ - 1;
  int               m_cur    = 0;
  logic [WIDTH-1:0] exp_rdata = '0;
  logic [NREQ-1:0]  released  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef ROM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return 0;
  endfunction

  // Reference: a free arbiter serves one winner per 3 edges; grant shows after
  // the deciding edge, data one edge later, requester freed one edge after that.
  task automatic model_step();
    exp_t e;
    int   w;
    released = '0;
    if (rst) begin
      m_phase   = 0;
      m_last    = NREQ - 1;
      exp_rdata = '0;
      gq.delete();
      rq.delete();
    end else if (m_phase == 0) begin
      if (bus.req != '0) begin
        w     = pick(bus.req, m_last);
        e.cyc = cyc;
        e.oh  = NREQ'(1) << w;
        e.a   = bus.addr[w*DEPTH +: DEPTH];
        e.d   = rom_mem[e.a];
        gq.push_back(e);
        e.cyc = cyc + 1;
        rq.push_back(e);
        m_cur   = w;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_phase  = 0;
      m_last   = m_cur;
      released[m_cur] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [DEPTH-1:0] a);
    bus.req[i] = v;
    bus.addr[i*DEPTH +: DEPTH] = a;
  endtask

  task automatic run(input int n, input logic [NREQ-1:0] keep);
    for (int k = 0; k < n; k++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (released[i] && !keep[i]) bus.req[i] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] er;
    if (mon_en) begin
      eg = '0;
      er = '0;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        check("rom_a", 32'(bus.rom_a), 32'(gq[0].a));
        eg = gq[0].oh;
        void'(gq.pop_front());
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        er        = rq[0].oh;
        exp_rdata = rq[0].d;
        void'(rq.pop_front());
      end
      check("gnt", 32'(bus.gnt), 32'(eg));
      check("rvalid", 32'(bus.rvalid), 32'(er));
      check("rdata", 32'(bus.rdata), 32'(exp_rdata));
    end
  end

  initial begin
    for (int k = 0; k < ROMN; k++) rom_mem[k] = WIDTH'(k + 1);
    bus.req  = '0;
    bus.addr = '0;

    // reset then idle
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rom_a_idle", 32'(bus.rom_a), 32'd0);
    end

    // contention, then wrap after requester 3 is served
    set_req(0, 1'b1, 4'h0);
    set_req(1, 1'b1, 4'h3);
    set_req(2, 1'b1, 4'h7);
    set_req(3, 1'b1, 4'hF);
    run(12, 4'b1111);
    bus.req[1] = 1'b0;
    bus.req[2] = 1'b0;
    run(6, 4'b0000);
    run(2, 4'b0000);

    // single read
    set_req(2, 1'b1, 4'h5);
    run(5, 4'b0000);

    // abandon during READ
    set_req(1, 1'b1, 4'h9);
    tick();
    bus.req[1] = 1'b0;
    run(5, 4'b0000);

    // reset while in READ, then contention restarts at requester 0
    set_req(2, 1'b1, 4'hC);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rom_a_after_rst", 32'(bus.rom_a), 32'd0);
    set_req(0, 1'b1, 4'h1);
    set_req(3, 1'b1, 4'hE);
    run(9, 4'b0000);
    run(2, 4'b0000);

    // randomized traffic with a fresh ROM image and occasional resets
    for (int k = 0; k < ROMN; k++) rom_mem[k] = WIDTH'($urandom);
    for (int n = 0; n < 600; n++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (released[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
          else bus.addr[i*DEPTH +: DEPTH] = DEPTH'($urandom);
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, 1'b1, DEPTH'($urandom));
        end
      end
    end
    rst = 1'b0;
    for (int n = 0; n < 80 && bus.req != '0; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (released[i]) bus.req[i] = 1'b0;
      end
    end
    checks++;
    if (bus.req != '0) begin
      errors++;
      $display("FAIL drain_timeout cyc=%0d actual=%h expected=0", cyc, bus.req);
    end
    run(4, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
